// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: start, DATA_BITS LSB-first, optional parity, 1-2 stop bits.
// txd is registered and aligned with state (start bit begins the cycle after acceptance); tx_ready only in IDLE.
module uart_tx_param #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       txd,
    output logic       busy,
    output logic       frame_done
);

    localparam int               BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic [7:0]       DATA_MASK = 8'((1 << DATA_BITS) - 1);
    localparam logic             PAR_ODD   = (PARITY == 2);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t            state, state_n;
    logic [BAUD_W-1:0] baud, baud_n;
    logic [2:0]        bit_cnt, bit_n;
    logic [7:0]        shreg, shreg_n;
    logic              par_bit, par_n;
    logic              txd_n;
    logic              baud_end;

    assign baud_end   = (baud == BAUD_LAST);
    assign tx_ready   = (state == IDLE);
    assign busy       = (state != IDLE);
    assign frame_done = (state == STOP) && baud_end && (bit_cnt == STOP_LAST) && !rst;

    always_comb begin
        state_n = state;
        baud_n  = baud;
        bit_n   = bit_cnt;
        shreg_n = shreg;
        par_n   = par_bit;
        if (state != IDLE)
            baud_n = baud_end ? '0 : baud + 1'b1;
        case (state)
            IDLE: begin
                if (tx_valid) begin
                    state_n = START;
                    shreg_n = tx_data & DATA_MASK;
                    // Parity is captured at acceptance since the shift register is consumed.
                    par_n   = (^(tx_data & DATA_MASK)) ^ PAR_ODD;
                    baud_n  = '0;
                    bit_n   = '0;
                end
            end
            START: begin
                if (baud_end) begin
                    state_n = DATA;
                    bit_n   = '0;
                end
            end
            DATA: begin
                if (baud_end) begin
                    shreg_n = shreg >> 1;
                    if (bit_cnt == DATA_LAST) begin
                        state_n = (PARITY != 0) ? PAR : STOP;
                        bit_n   = '0;
                    end else begin
                        bit_n = bit_cnt + 3'd1;
                    end
                end
            end
            PAR: begin
                if (baud_end) begin
                    state_n = STOP;
                    bit_n   = '0;
                end
            end
            STOP: begin
                if (baud_end) begin
                    if (bit_cnt == STOP_LAST) begin
                        state_n = IDLE;
                        bit_n   = '0;
                    end else begin
                        bit_n = bit_cnt + 3'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Line level derived from the next state so the register keeps txd aligned with state.
        case (state_n)
            START:   txd_n = 1'b0;
            DATA:    txd_n = shreg_n[0];
            PAR:     txd_n = par_n;
            default: txd_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            baud    <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            txd     <= 1'b1;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_cnt <= bit_n;
            shreg   <= shreg_n;
            par_bit <= par_n;
            txd     <= txd_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: four parameterisations sharing one clock and reset.
module tb_uart_tx_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       v0 = 1'b0, v1 = 1'b0, v2 = 1'b0, v3 = 1'b0;
    logic       rdy0, rdy1, rdy2, rdy3;
    logic       txd0, txd1, txd2, txd3;
    logic       busy0, busy1, busy2, busy3;
    logic       fd0, fd1, fd2, fd3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_tx_param u0 (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(v0),
        .tx_ready(rdy0), .txd(txd0), .busy(busy0), .frame_done(fd0)
    );
    uart_tx_param #(.DATA_BITS(7), .PARITY(1)) u1 (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(v1),
        .tx_ready(rdy1), .txd(txd1), .busy(busy1), .frame_done(fd1)
    );
    uart_tx_param #(.DATA_BITS(7), .PARITY(2)) u2 (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(v2),
        .tx_ready(rdy2), .txd(txd2), .busy(busy2), .frame_done(fd2)
    );
    uart_tx_param #(.CLKS_PER_BIT(2), .STOP_BITS(2)) u3 (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(v3),
        .tx_ready(rdy3), .txd(txd3), .busy(busy3), .frame_done(fd3)
    );

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (txd0 !== 1'b1) begin errors++; $display("FAIL reset_txd0 got %b want 1", txd0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy0 got %b want 0", busy0); end
        checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL reset_ready0 got %b want 1", rdy0); end
        checks++; if (fd0 !== 1'b0) begin errors++; $display("FAIL reset_done0 got %b want 0", fd0); end
        checks++; if ({txd1, txd2, txd3} !== 3'b111) begin errors++; $display("FAIL reset_txd_others got %b want 111", {txd1, txd2, txd3}); end
        checks++; if ({rdy1, rdy2, rdy3} !== 3'b111) begin errors++; $display("FAIL reset_ready_others got %b want 111", {rdy1, rdy2, rdy3}); end
        // reset wins over a simultaneous tx_valid
        v0 = 1'b1; tx_data = 8'h33;
        @(negedge clk);
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_priority_busy got %b want 0", busy0); end
        v0 = 1'b0; rst = 1'b0;
        @(negedge clk);
        checks++; if (busy0 !== 1'b0 || txd0 !== 1'b1) begin errors++; $display("FAIL reset_priority_idle busy=%b txd=%b want 0/1", busy0, txd0); end
    endtask

    task automatic test_basic();
        string s = "0110011001";
        logic  e;
        @(negedge clk);
        tx_data = 8'h33; v0 = 1'b1;
        for (int c = 1; c <= 161; c++) begin
            @(negedge clk);
            if (c == 1) begin v0 = 1'b0; tx_data = 8'hFF; end
            if (c <= 160) begin
                e = (s[(c-1)/16] == "1");
                checks++; if (txd0 !== e) begin errors++; $display("FAIL basic_txd cycle %0d got %b want %b", c, txd0, e); end
                checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL basic_busy cycle %0d got %b want 1", c, busy0); end
                checks++; if (fd0 !== (c == 160)) begin errors++; $display("FAIL basic_done cycle %0d got %b want %b", c, fd0, (c == 160)); end
            end else begin
                checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL basic_ready_after got %b want 1", rdy0); end
                checks++; if (txd0 !== 1'b1 || busy0 !== 1'b0 || fd0 !== 1'b0) begin errors++; $display("FAIL basic_idle_after txd=%b busy=%b done=%b want 1/0/0", txd0, busy0, fd0); end
            end
        end
    endtask

    task automatic test_parity();
        string se = "0101010101";
        string so = "0101010111";
        logic  ee, eo;
        @(negedge clk);
        tx_data = 8'hD5; v1 = 1'b1; v2 = 1'b1;
        for (int c = 1; c <= 161; c++) begin
            @(negedge clk);
            if (c == 1) begin v1 = 1'b0; v2 = 1'b0; end
            if (c <= 160) begin
                ee = (se[(c-1)/16] == "1");
                eo = (so[(c-1)/16] == "1");
                checks++; if (txd1 !== ee) begin errors++; $display("FAIL parity_even_txd cycle %0d got %b want %b", c, txd1, ee); end
                checks++; if (txd2 !== eo) begin errors++; $display("FAIL parity_odd_txd cycle %0d got %b want %b", c, txd2, eo); end
                checks++; if ({fd1, fd2} !== {2{c == 160}}) begin errors++; $display("FAIL parity_done cycle %0d got %b", c, {fd1, fd2}); end
            end else begin
                checks++; if ({rdy1, rdy2} !== 2'b11) begin errors++; $display("FAIL parity_ready_after got %b want 11", {rdy1, rdy2}); end
            end
        end
    endtask

    task automatic test_back_to_back();
        string f1 = "0101001011";
        string f2 = "0010110101";
        logic  e;
        int    pulses = 0;
        @(negedge clk);
        tx_data = 8'hA5; v0 = 1'b1;
        for (int c = 1; c <= 322; c++) begin
            @(negedge clk);
            if (c == 1) tx_data = 8'h5A;
            if (c == 162) v0 = 1'b0;
            if (c <= 160)      e = (f1[(c-1)/16] == "1");
            else if (c == 161) e = 1'b1;
            else if (c <= 321) e = (f2[(c-162)/16] == "1");
            else               e = 1'b1;
            if (fd0 === 1'b1) pulses++;
            checks++; if (txd0 !== e) begin errors++; $display("FAIL b2b_txd cycle %0d got %b want %b", c, txd0, e); end
            checks++; if (fd0 !== (c == 160 || c == 321)) begin errors++; $display("FAIL b2b_done cycle %0d got %b", c, fd0); end
            if (c == 161) begin
                checks++; if (rdy0 !== 1'b1 || busy0 !== 1'b0) begin errors++; $display("FAIL b2b_gap ready=%b busy=%b want 1/0", rdy0, busy0); end
            end
        end
        checks++; if (pulses != 2) begin errors++; $display("FAIL b2b_pulse_count got %0d want 2", pulses); end
    endtask

    task automatic test_reset_mid();
        string s = "0111100001";
        logic  e;
        int    pulses = 0;
        @(negedge clk);
        tx_data = 8'h33; v0 = 1'b1;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            if (c == 1) v0 = 1'b0;
            if (fd0 === 1'b1) pulses++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (txd0 !== 1'b1) begin errors++; $display("FAIL midrst_txd got %b want 1", txd0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy0); end
        checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", rdy0); end
        repeat (100) begin
            @(negedge clk);
            if (fd0 === 1'b1 || txd0 !== 1'b1) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL midrst_no_done got %0d events want 0", pulses); end
        tx_data = 8'h0F; v0 = 1'b1;
        for (int c = 1; c <= 160; c++) begin
            @(negedge clk);
            if (c == 1) v0 = 1'b0;
            e = (s[(c-1)/16] == "1");
            checks++; if (txd0 !== e) begin errors++; $display("FAIL midrst_clean_txd cycle %0d got %b want %b", c, txd0, e); end
            checks++; if (fd0 !== (c == 160)) begin errors++; $display("FAIL midrst_clean_done cycle %0d got %b", c, fd0); end
        end
    endtask

    task automatic test_two_stop();
        logic e;
        @(negedge clk);
        tx_data = 8'h00; v3 = 1'b1;
        for (int c = 1; c <= 23; c++) begin
            @(negedge clk);
            if (c == 1) v3 = 1'b0;
            if (c <= 22) begin
                e = (c > 18);
                checks++; if (txd3 !== e) begin errors++; $display("FAIL stop2_txd cycle %0d got %b want %b", c, txd3, e); end
                checks++; if (busy3 !== 1'b1) begin errors++; $display("FAIL stop2_busy cycle %0d got %b want 1", c, busy3); end
                checks++; if (fd3 !== (c == 22)) begin errors++; $display("FAIL stop2_done cycle %0d got %b", c, fd3); end
            end else begin
                checks++; if (busy3 !== 1'b0 || rdy3 !== 1'b1) begin errors++; $display("FAIL stop2_end busy=%b ready=%b want 0/1", busy3, rdy3); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_back_to_back();
        test_reset_mid();
        test_two_stop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clk cycles per bit period; legal range >= 2.
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range 5..8.
REQ-003 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port tx_data, input, 8 bits: frame payload; bits [7:DATA_BITS] ignored.
REQ-008 SHALL have port tx_valid, input, 1 bit: tx_data holds a byte to send.
REQ-009 SHALL have port tx_ready, output, 1 bit: block can accept a byte this cycle.
REQ-010 SHALL have port txd, output, 1 bit: serial line, idle high, registered.
REQ-011 SHALL have port busy, output, 1 bit: frame in progress (state != IDLE).
REQ-012 SHALL have port frame_done, output, 1 bit: one-cycle pulse at end of frame.

Function
REQ-013 SHALL implement FSM states IDLE, START, DATA, PAR, STOP; PAR entered only when PARITY != 0.
REQ-014 SHALL drive tx_ready = 1 only in IDLE (combinational from state), 0 otherwise.
REQ-015 SHALL accept a byte when tx_valid && tx_ready at a rising edge, latch tx_data into a shift register, and enter START next cycle.
REQ-016 SHALL ignore tx_data and tx_valid changes while busy; the latched copy is transmitted.
REQ-017 SHALL hold each bit (start, each data, parity, each stop) on txd for exactly CLKS_PER_BIT cycles, timed by a baud counter of width clog2(CLKS_PER_BIT), cleared at every bit boundary.
REQ-018 SHALL drive txd = 0 during START, data LSB first during DATA, parity during PAR, 1 during STOP and IDLE.
REQ-019 SHALL count data bits 0..DATA_BITS-1 and leave DATA after bit DATA_BITS-1 completes.
REQ-020 SHALL compute parity over the DATA_BITS latched bits only: even = XOR of bits, odd = inverted XOR.
REQ-021 SHALL hold STOP for STOP_BITS*CLKS_PER_BIT cycles, then return to IDLE.
REQ-022 SHALL pulse frame_done high for exactly the last cycle of the final stop bit.
REQ-023 SHALL make txd follow the FSM with one register stage: first start-bit cycle on txd is the cycle after acceptance.
REQ-024 SHALL spend exactly one IDLE cycle between back-to-back frames when tx_valid is held high; no bit period is shortened or stretched.
REQ-025 SHALL produce total frame length (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles from first start cycle to last stop cycle.

Reset
REQ-026 SHALL, on rst high at a rising edge, set state IDLE, txd 1, busy 0, frame_done 0, baud and bit counters 0, shift register 0; tx_ready 1 after that edge.
REQ-027 SHALL, on reset mid-frame, abandon the frame with no frame_done pulse; txd high from the next edge.
REQ-028 SHALL give rst priority over a simultaneous tx_valid; the byte is not accepted.

Verification
REQ-029 SHALL verify defaults, tx_data 0x33 accepted -> txd 0,1,1,0,0,1,1,0,0,1 each 16 cycles, frame_done at cycle 160 after the first start cycle, tx_ready high next cycle.
REQ-030 SHALL verify DATA_BITS=7, PARITY=1, tx_data 0xD5 -> data 1010101 LSB first, parity 0, bit 7 ignored; PARITY=2 same data -> parity 1.
REQ-031 SHALL verify tx_valid held with 0xA5 then 0x5A -> two complete frames separated by exactly one idle-high cycle, two frame_done pulses.
REQ-032 SHALL verify rst asserted during data bit 3 -> txd 1, busy 0, tx_ready 1 after the edge, no frame_done, next accepted byte sent as a clean frame.
REQ-033 SHALL verify STOP_BITS=2, CLKS_PER_BIT=2, tx_data 0x00 -> start plus 8 zeros each 2 cycles, stop high 4 cycles, total 22 cycles.
